// File: rtl/debouncer_multi_if.sv
// debouncer_multi_if: raw inputs and filtered outputs of the multi-channel debouncer.
interface debouncer_multi_if #(parameter int CHANNELS = 4);
    logic [CHANNELS-1:0] noisy;
    logic [CHANNELS-1:0] debounced;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] long_press;
    modport master (output noisy, input debounced, rise, fall, long_press);
    modport slave (input noisy, output debounced, rise, fall, long_press);
endinterface

// File: rtl/debouncer_multi.sv
// debouncer_multi: independent per-channel synchronizer, four-state debounce FSM,
// edge pulses and optional long-press detection.
module debouncer_multi #(
    parameter int CHANNELS    = 4,
    parameter int FINAL_VALUE = 1_999_999,
    parameter int CNT_W       = 21,
    parameter int LONG_VALUE  = 0,
    parameter int LONG_W      = 28
) (
    input logic clk,
    input logic reset,
    debouncer_multi_if.slave bus
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(FINAL_VALUE);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [1:0] sync_q, sync_d;
        logic deb_q, deb_d, rise_q, rise_d, fall_q, fall_d;
        always_comb begin
            sync_d = {sync_q[0], bus.noisy[i]};
            state_d = state_q;
            cnt_d = cnt_q;
            case (state_q)
                ZERO: if (sync_q[1]) begin
                    state_d = WAIT1;
                    cnt_d = '0;
                end
                WAIT1: if (!sync_q[1]) state_d = ZERO;
                    else if (cnt_q == CNT_END) state_d = ONE;
                    else cnt_d = cnt_q + 1'b1;
                ONE: if (!sync_q[1]) begin
                    state_d = WAIT0;
                    cnt_d = '0;
                end
                default: if (sync_q[1]) state_d = ONE;
                    else if (cnt_q == CNT_END) state_d = ZERO;
                    else cnt_d = cnt_q + 1'b1;
            endcase
            deb_d = state_d == ONE || state_d == WAIT0;
            rise_d = deb_d & ~deb_q;
            fall_d = ~deb_d & deb_q;
        end
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
                state_q <= ZERO;
                cnt_q <= '0;
                deb_q <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                sync_q <= sync_d;
                state_q <= state_d;
                cnt_q <= cnt_d;
                deb_q <= deb_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
            end
        end
        assign bus.debounced[i] = deb_q;
        assign bus.rise[i] = rise_q;
        assign bus.fall[i] = fall_q;
        if (LONG_VALUE > 0) begin : g_long
            localparam logic [LONG_W-1:0] HOLD_END = LONG_W'(LONG_VALUE);
            logic [LONG_W-1:0] hold_q, hold_d;
            logic lp_q, lp_d;
            // Only a fresh press (WAIT1->ONE) restarts the hold; a bounce back from WAIT0 keeps it.
            always_comb begin
                hold_d = (state_q == WAIT1 && state_d == ONE) ? '0 :
                         (deb_q && hold_q != HOLD_END) ? hold_q + 1'b1 : hold_q;
                lp_d = hold_d == HOLD_END && hold_q != HOLD_END;
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hold_q <= '0;
                    lp_q <= 1'b0;
                end else begin
                    hold_q <= hold_d;
                    lp_q <= lp_d;
                end
            end
            assign bus.long_press[i] = lp_q;
        end else begin : g_nolong
            assign bus.long_press[i] = 1'b0;
        end
    end
endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: random and directed stimulus; a run-length reference model feeds
// an event scoreboard that a separate monitor drains.
module tb_debouncer_multi;
    localparam int CH = 4, FV = 9, LV = 20;
    typedef struct {int cyc; int ch; int kind;} ev_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    bit done = 1'b0;
    int cyc = 0;
    int total = 0, bad = 0;
    ev_t exp_q[$];
    bit m_deb[CH], h1[CH], h2[CH];
    int m_run[CH], m_since[CH];

    debouncer_multi_if #(.CHANNELS(CH)) bus();
    debouncer_multi #(.CHANNELS(CH), .FINAL_VALUE(FV), .CNT_W(4), .LONG_VALUE(LV), .LONG_W(5))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic void push_ev(input int c, input int k);
        ev_t e;
        e.cyc = cyc;
        e.ch = c;
        e.kind = k;
        exp_q.push_back(e);
    endfunction

    // Reference: the FSM sees noisy two edges late; the level flips after FV+2
    // consecutive disagreeing samples; long press fires LV cycles after a rise.
    always @(posedge clk) begin
        cyc++;
        for (int c = 0; c < CH; c++) begin
            bit s, r, f, l;
            r = 0; f = 0; l = 0;
            if (reset) begin
                m_deb[c] = 0; m_run[c] = 0; m_since[c] = 0; h1[c] = 0; h2[c] = 0;
            end else begin
                s = h2[c];
                h2[c] = h1[c];
                h1[c] = bus.noisy[c];
                if (m_deb[c] && m_since[c] < LV) begin
                    m_since[c]++;
                    l = m_since[c] == LV;
                end
                if (s != m_deb[c]) begin
                    m_run[c]++;
                    if (m_run[c] == FV + 2) begin
                        m_deb[c] = s; m_run[c] = 0; r = s; f = !s;
                        if (s) m_since[c] = 0;
                    end
                end else m_run[c] = 0;
                if (r) push_ev(c, 0);
                if (f) push_ev(c, 1);
                if (l) push_ev(c, 2);
            end
        end
    end

    initial begin
        ev_t e;
        logic [2:0] p;
        forever begin
            @(negedge clk or posedge reset or posedge done);
            if (done) break;
            #1;
            if (reset) begin
                total++;
                if ({bus.debounced, bus.rise, bus.fall, bus.long_press} != '0) begin
                    bad++;
                    $display("FAIL reset_zero cyc=%0d got deb=%b rise=%b fall=%b lp=%b want all 0",
                             cyc, bus.debounced, bus.rise, bus.fall, bus.long_press);
                end
            end else begin
                for (int c = 0; c < CH; c++) begin
                    total++;
                    if (bus.debounced[c] !== m_deb[c]) begin
                        bad++;
                        $display("FAIL level cyc=%0d ch=%0d got %b want %b", cyc, c, bus.debounced[c], m_deb[c]);
                    end
                    total++;
                    if (bus.rise[c] && bus.fall[c]) begin
                        bad++;
                        $display("FAIL rise_fall_excl cyc=%0d ch=%0d got both 1 want at most one", cyc, c);
                    end
                    p = {bus.long_press[c], bus.fall[c], bus.rise[c]};
                    for (int k = 0; k < 3; k++) if (p[k]) begin
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected cyc=%0d ch=%0d kind=%0d want no pulse", cyc, c, k);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.cyc != cyc || e.ch != c || e.kind != k) begin
                                bad++;
                                $display("FAIL event got cyc=%0d ch=%0d kind=%0d want cyc=%0d ch=%0d kind=%0d",
                                         cyc, c, k, e.cyc, e.ch, e.kind);
                            end
                        end
                    end
                end
                while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    e = exp_q.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missing got none want cyc=%0d ch=%0d kind=%0d", e.cyc, e.ch, e.kind);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        #3 reset = 1'b1;
        wait_cyc(n);
        #3 reset = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        bus.noisy = '0;
        wait_cyc(3);
        #3 reset = 1'b0;
        wait_cyc(1);
        bus.noisy[0] = 1'b1;
        wait_cyc(20);
        for (int k = 0; k < 4; k++) begin
            bus.noisy[1] = (k % 2 == 0);
            wait_cyc(3);
        end
        bus.noisy[1] = 1'b1;
        wait_cyc(20);
        bus.noisy[2] = 1'b1;
        wait_cyc(27);
        bus.noisy[2] = 1'b0;
        wait_cyc(3);
        bus.noisy[2] = 1'b1;
        wait_cyc(25);
        bus.noisy[2] = 1'b0;
        wait_cyc(20);
        bus.noisy = '0;
        wait_cyc(20);
        bus.noisy = 4'hf;
        wait_cyc(15);
        bus.noisy[3] = 1'b0;
        wait_cyc(5);
        bus.noisy[3] = 1'b1;
        wait_cyc(30);
        bus.noisy = '0;
        wait_cyc(20);
        bus.noisy[0] = 1'b1;
        wait_cyc(8);
        do_reset(3);
        wait_cyc(20);
        for (int seg = 0; seg < 3; seg++) begin
            int pr, rst_at;
            pr = (seg == 0) ? 3 : (seg == 1) ? 12 : 30;
            rst_at = (seg == 1) ? int'($urandom_range(100, 500)) : -1;
            for (int n = 0; n < 600; n++) begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(pr - 1) == 0) bus.noisy[c] = ~bus.noisy[c];
                if (n == rst_at) do_reset(2);
                else wait_cyc(1);
            end
        end
        wait_cyc(50);
        #3 done = 1'b1;
    end
endmodule
